// File: rtl/mem_bus_if.sv
// Bus-side handshake between the memory controller and the bus slave.
interface mem_bus_if;
   logic        bus_req;
   logic [3:0]  bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: turns a MEM-stage access into a single bus
// transaction, stalling the pipeline until the slave acks or the access times out.
//
// state | meaning
// IDLE  | no access pending; a valid ram_en starts one (stall raised same cycle)
// REQ   | bus_req held with latched address/strobes/data until ack or timeout
// DONE  | one-cycle result: read_valid or bus_error, pipeline released
module mem_bus_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ram_en,
   input  logic [3:0]  ram_write_en,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_write_data,
   input  logic        addr_err,
   input  logic        flush,
   mem_bus_if.master   bus,
   output logic        stall_req,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        bus_error
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        discard_q, discard_d;
   logic        bus_req_c;
   logic        start;

   // rst_n is folded in so stall_req stays low while reset is held,
   // even if ram_en is already asserted.
   assign start = ram_en & ~addr_err & ~flush & rst_n;

   // State and latched access registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         we_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         discard_q <= discard_d;
      end
   end

   // Next-state, register updates and state-decoded outputs.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      discard_d  = discard_q;
      stall_req  = 1'b0;
      bus_req_c  = 1'b0;
      read_valid = 1'b0;
      bus_error  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               stall_req = 1'b1;
               addr_d    = ram_addr;
               we_d      = ram_write_en;
               wdata_d   = ram_write_data;
               cnt_d     = '0;
               err_d     = 1'b0;
               discard_d = 1'b0;
               state_d   = REQ;
            end
         end
         REQ: begin
            stall_req = 1'b1;
            bus_req_c = 1'b1;
            // A flush cannot abort a bus transfer already in flight; the
            // result is simply dropped when it arrives.
            if (flush) discard_d = 1'b1;
            if (bus.bus_ack) begin
               if (we_q == 4'b0000) rdata_d = bus.bus_rdata;
               state_d = DONE;
            end else if (cnt_q == CNT_TC) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            read_valid = (we_q == 4'b0000) & ~err_q & ~discard_q;
            bus_error  = err_q;
            // ram_en is still high here for the same instruction; ignore it.
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.bus_req   = bus_req_c;
   assign bus.bus_we    = bus_req_c ? we_q : 4'b0000;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign read_data     = rdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a short timeout.
module tb_mem_bus_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ram_en;
   logic [3:0]  ram_write_en;
   logic [31:0] ram_addr;
   logic [31:0] ram_write_data;
   logic        addr_err;
   logic        flush;
   logic        stall_req;
   logic [31:0] read_data;
   logic        read_valid;
   logic        bus_error;

   mem_bus_if bus_if ();

   mem_bus_ctrl #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ram_en         (ram_en),
      .ram_write_en   (ram_write_en),
      .ram_addr       (ram_addr),
      .ram_write_data (ram_write_data),
      .addr_err       (addr_err),
      .flush          (flush),
      .bus            (bus_if.master),
      .stall_req      (stall_req),
      .read_data      (read_data),
      .read_valid     (read_valid),
      .bus_error      (bus_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;    // REQ cycle index carrying ack; >= TO means never
      int          flush_at;  // REQ cycle index carrying flush; -1 means none
      logic        exp_rv;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_req;
   } vec_t;

   vec_t vecs [8];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int  req_cycles;
      bit  done;
      req_cycles = 0;
      done = 0;
      @(negedge clk);
      ram_en         = 1'b1;
      ram_write_en   = v.we;
      ram_addr       = v.addr;
      ram_write_data = v.wdata;
      #1;
      chk($sformatf("v%0d start stall", idx), 32'(stall_req), 32'd1);
      chk($sformatf("v%0d start bus_req", idx), 32'(bus_if.bus_req), 32'd0);
      for (int c = 0; c < 3 * TO && !done; c++) begin
         @(negedge clk);
         if (bus_if.bus_req) begin
            chk($sformatf("v%0d req stall", idx), 32'(stall_req), 32'd1);
            chk($sformatf("v%0d req we", idx), 32'(bus_if.bus_we), 32'(v.we));
            chk($sformatf("v%0d req addr", idx), bus_if.bus_addr, v.addr);
            chk($sformatf("v%0d req wdata", idx), bus_if.bus_wdata, v.wdata);
            chk($sformatf("v%0d req rv", idx), 32'(read_valid), 32'd0);
            bus_if.bus_ack   = (req_cycles == v.ack_at);
            bus_if.bus_rdata = (req_cycles == v.ack_at) ? v.rdata : 32'hA5A5_0000 + 32'(req_cycles);
            flush            = (req_cycles == v.flush_at);
            req_cycles++;
         end else begin
            done = 1;
            bus_if.bus_ack = 1'b0;
            flush          = 1'b0;
            chk($sformatf("v%0d done stall", idx), 32'(stall_req), 32'd0);
            chk($sformatf("v%0d done bus_we", idx), 32'(bus_if.bus_we), 32'd0);
            chk($sformatf("v%0d done rv", idx), 32'(read_valid), 32'(v.exp_rv));
            chk($sformatf("v%0d done rd", idx), read_data, v.exp_rd);
            chk($sformatf("v%0d done err", idx), 32'(bus_error), 32'(v.exp_err));
            ram_en = 1'b0;
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL v%0d done_wait: got no DONE, expected within %0d cycles", idx, 3 * TO);
      end
      chk($sformatf("v%0d req_cycles", idx), 32'(req_cycles), 32'(v.exp_req));
      @(negedge clk);
      chk($sformatf("v%0d idle rv", idx), 32'(read_valid), 32'd0);
      chk($sformatf("v%0d idle err", idx), 32'(bus_error), 32'd0);
      chk($sformatf("v%0d idle rd hold", idx), read_data, v.exp_rd);
      chk($sformatf("v%0d idle bus_req", idx), 32'(bus_if.bus_req), 32'd0);
   endtask

   initial begin
      vec_t v;
      //          we       addr          wdata         rdata         ack flush rv  rd            err req
      vecs[0] = '{4'b0000, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0,  -1,  1, 32'hDEAD_BEEF, 0, 1};
      vecs[1] = '{4'b0100, 32'h0000_2004, 32'h00AB_0000, 32'h1234_5678, 4,  -1,  0, 32'hDEAD_BEEF, 0, 5};
      vecs[2] = '{4'b0000, 32'h0000_3008, 32'h0,        32'hCAFE_F00D, 2,   1,  0, 32'hCAFE_F00D, 0, 3};
      vecs[3] = '{4'b0000, 32'h0000_400C, 32'h0,        32'h1111_1111, 99, -1,  0, 32'h0,         1, TO};
      vecs[4] = '{4'b0000, 32'h0000_5010, 32'h0,        32'h0BAD_F00D, 1,  -1,  1, 32'h0BAD_F00D, 0, 2};
      vecs[5] = '{4'b1111, 32'h0000_6014, 32'hFEED_FACE, 32'h2222_2222, 0,  -1,  0, 32'h0BAD_F00D, 0, 1};
      vecs[6] = '{4'b0011, 32'h0000_7018, 32'h0000_BEEF, 32'h3333_3333, 99, -1,  0, 32'h0,         1, TO};
      vecs[7] = '{4'b0000, 32'h0000_801C, 32'h0,        32'h55AA_55AA, TO-1, -1, 1, 32'h55AA_55AA, 0, TO};

      rst_n = 1'b0;
      ram_en = 1'b0;
      ram_write_en = 4'b0;
      ram_addr = 32'h0;
      ram_write_data = 32'h0;
      addr_err = 1'b0;
      flush = 1'b0;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = 32'h0;

      repeat (2) @(negedge clk);
      chk("rst bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("rst bus_addr", bus_if.bus_addr, 32'd0);
      chk("rst stall", 32'(stall_req), 32'd0);
      chk("rst read_data", read_data, 32'd0);
      chk("rst rv", 32'(read_valid), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

      // Rejected starts: addr_err or flush with ram_en leave the bus idle.
      @(negedge clk);
      ram_en = 1'b1;
      addr_err = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("addr_err stall", 32'(stall_req), 32'd0);
         chk("addr_err bus_req", 32'(bus_if.bus_req), 32'd0);
         @(negedge clk);
      end
      addr_err = 1'b0;
      flush = 1'b1;
      #1;
      chk("flush idle stall", 32'(stall_req), 32'd0);
      @(negedge clk);
      chk("flush idle bus_req", 32'(bus_if.bus_req), 32'd0);
      flush = 1'b0;
      ram_en = 1'b0;

      // Reset in the middle of REQ.
      @(negedge clk);
      ram_en = 1'b1;
      ram_write_en = 4'b0000;
      ram_addr = 32'h0000_9020;
      @(negedge clk);
      chk("pre-rst bus_req", 32'(bus_if.bus_req), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid-rst bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("mid-rst stall", 32'(stall_req), 32'd0);
      chk("mid-rst bus_addr", bus_if.bus_addr, 32'd0);
      @(negedge clk);
      ram_en = 1'b0;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("post-rst no retry", 32'(bus_if.bus_req), 32'd0);
      end
      v = '{4'b0000, 32'h0000_A024, 32'h0, 32'h1357_9BDF, 0, -1, 1, 32'h1357_9BDF, 0, 1};
      run_txn(v, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
